// File: rtl/morse_key_timer.sv
// Straight-key timing front end: turns a debounced key level into dot/dash/done/space
// strobes for the letter trie, measuring press and release lengths in Morse units.
module morse_key_timer #(
  parameter int TICK_DIV         = 1_000_000,
  parameter int DOT_MAX_UNITS    = 2,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7,
  parameter int MAX_SYMBOLS      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       key,
  output logic       dot_pulse,
  output logic       dash_pulse,
  output logic       done_pulse,
  output logic       space_pulse,
  output logic       overflow,
  output logic       busy,
  output logic [2:0] sym_count
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int UW = $clog2(WORD_GAP_UNITS + 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [UW-1:0] UNIT_SAT  = UW'(WORD_GAP_UNITS);
  localparam logic [UW-1:0] DOT_LIM   = UW'(DOT_MAX_UNITS);
  localparam logic [UW-1:0] LETTER_PRE = UW'(LETTER_GAP_UNITS - 1);
  localparam logic [UW-1:0] WORD_PRE   = UW'(WORD_GAP_UNITS - 1);
  localparam logic [2:0]    MAX_SYM    = 3'(MAX_SYMBOLS);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD_WAIT} state_t;

  state_t        state, stateNext;
  logic          keyMeta, keyS, keyD;
  logic [2:0]    vldPipe;
  logic          rise, fall, tick;
  logic [PW-1:0] presc;
  logic [UW-1:0] unitCnt;
  logic          letterHit, wordHit, canIssue;
  logic          issueSym, isDash, doneNext, spaceNext;

  // vldPipe holds off edge detection until keyD carries a real sample, so a key
  // already held when reset releases is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keyMeta <= 1'b0;
      keyS    <= 1'b0;
      keyD    <= 1'b0;
      vldPipe <= '0;
    end else begin
      keyMeta <= key;
      keyS    <= keyMeta;
      keyD    <= keyS;
      vldPipe <= {vldPipe[1:0], 1'b1};
    end
  end

  assign rise = vldPipe[2] & keyS & ~keyD;
  assign fall = vldPipe[2] & ~keyS & keyD;
  assign tick = (presc == PRESC_TOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      unitCnt <= '0;
    end else begin
      if (!enable || rise || fall || tick) presc <= '0;
      else                                 presc <= presc + 1'b1;
      if (!enable || rise || fall)               unitCnt <= '0;
      else if (tick && unitCnt != UNIT_SAT)      unitCnt <= unitCnt + 1'b1;
    end
  end

  // Gap strobes are decided on the tick that moves unitCnt onto the threshold,
  // so they appear the cycle the count lands there.
  assign letterHit = tick && (unitCnt == LETTER_PRE);
  assign wordHit   = tick && (unitCnt == WORD_PRE);
  assign canIssue  = (sym_count < MAX_SYM);

  always_comb begin
    stateNext = state;
    issueSym  = 1'b0;
    isDash    = 1'b0;
    doneNext  = 1'b0;
    spaceNext = 1'b0;
    case (state)
      IDLE: if (rise) stateNext = PRESS;
      PRESS:
        if (fall) begin
          issueSym  = 1'b1;
          isDash    = (unitCnt >= DOT_LIM);
          stateNext = GAP;
        end
      GAP:
        if (rise) stateNext = PRESS;
        else if (letterHit) begin
          doneNext  = 1'b1;
          stateNext = WORD_WAIT;
        end
      WORD_WAIT:
        if (rise) stateNext = PRESS;
        else if (wordHit) begin
          spaceNext = 1'b1;
          stateNext = IDLE;
        end
      default: stateNext = IDLE;
    endcase
    if (!enable) begin
      stateNext = IDLE;
      issueSym  = 1'b0;
      doneNext  = 1'b0;
      spaceNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dot_pulse   <= 1'b0;
      dash_pulse  <= 1'b0;
      done_pulse  <= 1'b0;
      space_pulse <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      sym_count   <= '0;
    end else begin
      state       <= stateNext;
      dot_pulse   <= issueSym & canIssue & ~isDash;
      dash_pulse  <= issueSym & canIssue & isDash;
      done_pulse  <= doneNext;
      space_pulse <= spaceNext;
      busy        <= (stateNext != IDLE);
      if (!enable || doneNext)      sym_count <= '0;
      else if (issueSym && canIssue) sym_count <= sym_count + 1'b1;
      // Overflow survives the letter's done so it can be read in WORD_WAIT.
      if (!enable)                                       overflow <= 1'b0;
      else if (issueSym && !canIssue)                    overflow <= 1'b1;
      else if (rise && (state == WORD_WAIT || state == IDLE)) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morse_key_timer.sv
// Scoreboard bench for morse_key_timer: stimulus queues hand-computed strobe events,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_morse_key_timer;

  logic       clk = 1'b0;
  logic       reset_n, enable, key;
  logic       dot_pulse, dash_pulse, done_pulse, space_pulse, overflow, busy;
  logic [2:0] sym_count;

  morse_key_timer #(
    .TICK_DIV(4), .DOT_MAX_UNITS(2), .LETTER_GAP_UNITS(3),
    .WORD_GAP_UNITS(7), .MAX_SYMBOLS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .key(key),
    .dot_pulse(dot_pulse), .dash_pulse(dash_pulse), .done_pulse(done_pulse),
    .space_pulse(space_pulse), .overflow(overflow), .busy(busy), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int kind; int cyc; int sc; int ov;} ev_t;
  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  mKind;
  ev_t mEv;

  // kinds: 0 dot, 1 dash, 2 done, 3 space
  always @(negedge clk) begin
    if (reset_n && (dot_pulse || dash_pulse || done_pulse || space_pulse)) begin
      mKind = dot_pulse ? 0 : dash_pulse ? 1 : done_pulse ? 2 : 3;
      checks++;
      if ($countones({dot_pulse, dash_pulse, done_pulse, space_pulse}) > 1) begin
        errors++;
        $display("FAIL strobe_onehot: got %b at cyc %0d, required at most one high", {dot_pulse, dash_pulse, done_pulse, space_pulse}, cyc);
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got kind=%0d at cyc %0d, required no strobe", mKind, cyc);
      end else begin
        mEv = q.pop_front();
        if (mKind != mEv.kind || cyc != mEv.cyc || int'(sym_count) != mEv.sc || int'(overflow) != mEv.ov) begin
          errors++;
          $display("FAIL strobe_event: got kind=%0d cyc=%0d sc=%0d ov=%0d, required kind=%0d cyc=%0d sc=%0d ov=%0d",
                   mKind, cyc, sym_count, overflow, mEv.kind, mEv.cyc, mEv.sc, mEv.ov);
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int kind, input int at, input int sc, input int ov);
    ev_t e;
    e.kind = kind; e.cyc = at; e.sc = sc; e.ov = ov;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic plainDot();
    int c;
    c = cyc;
    push(0, c + 7, 1, 0); push(2, c + 19, 0, 0); push(3, c + 35, 0, 0);
    key = 1; hold(4); key = 0; hold(40);
  endtask

  int c;

  initial begin
    reset_n = 0; enable = 1; key = 0;
    hold(3);
    chk("reset_busy", busy, 0);
    chk("reset_symcount", sym_count, 0);
    chk("reset_strobes", {dot_pulse, dash_pulse, done_pulse, space_pulse, overflow}, 0);
    reset_n = 1;
    hold(5);

    // "A": dot then dash
    c = cyc;
    push(0, c + 7, 1, 0); push(1, c + 23, 2, 0); push(2, c + 35, 0, 0); push(3, c + 51, 0, 0);
    key = 1; hold(4); key = 0; hold(4);
    chk("A_symcount_after_dot", sym_count, 1);
    key = 1; hold(12); key = 0; hold(5);
    chk("A_symcount_after_dash", sym_count, 2);
    hold(35);

    // "E", 16-clk letter gap, "T"
    c = cyc;
    push(0, c + 7, 1, 0); push(2, c + 19, 0, 0); push(1, c + 35, 1, 0);
    push(2, c + 47, 0, 0); push(3, c + 63, 0, 0);
    key = 1; hold(4); key = 0; hold(16); key = 1; hold(12); key = 0; hold(40);

    // five dots overflow the four-symbol letter
    c = cyc;
    for (int i = 0; i < 4; i++) push(0, c + 8 * i + 7, i + 1, 0);
    push(2, c + 51, 0, 1);
    push(0, c + 63, 1, 0); push(2, c + 75, 0, 0); push(3, c + 91, 0, 0);
    for (int i = 0; i < 5; i++) begin key = 1; hold(4); key = 0; hold(4); end
    hold(4);
    chk("ovf_set", overflow, 1);
    chk("ovf_symcount_held", sym_count, 4);
    hold(12);
    chk("ovf_held_in_word_wait", overflow, 1);
    key = 1; hold(4);
    chk("ovf_cleared_on_rise", overflow, 0);
    key = 0; hold(40);

    // 12-clk release: rise lands on the gap tick, no done; 13-clk release: done then new letter
    c = cyc;
    push(0, c + 7, 1, 0); push(0, c + 23, 2, 0); push(2, c + 35, 0, 0);
    push(0, c + 40, 1, 0); push(2, c + 52, 0, 0); push(3, c + 68, 0, 0);
    key = 1; hold(4); key = 0; hold(12); key = 1; hold(4);
    key = 0; hold(13); key = 1; hold(4); key = 0; hold(40);

    // enable drop during GAP discards the letter
    c = cyc;
    push(0, c + 7, 1, 0); push(1, c + 23, 2, 0);
    key = 1; hold(4); key = 0; hold(4); key = 1; hold(12); key = 0; hold(6);
    chk("en_symcount_before", sym_count, 2);
    chk("en_busy_before", busy, 1);
    enable = 0; hold(2);
    chk("en_symcount_cleared", sym_count, 0);
    chk("en_busy_cleared", busy, 0);
    chk("en_ovf_cleared", overflow, 0);
    hold(10); key = 1; hold(20); enable = 1; hold(20);
    chk("en_held_key_no_press", busy, 0);
    key = 0; hold(8);
    plainDot();

    // async reset mid-letter, then key held through release
    c = cyc;
    push(0, c + 7, 1, 0);
    key = 1; hold(4); key = 0; hold(4); key = 1; hold(6);
    chk("rst_symcount_before", sym_count, 1);
    chk("rst_busy_before", busy, 1);
    reset_n = 0; #2;
    chk("rst_busy", busy, 0);
    chk("rst_symcount", sym_count, 0);
    chk("rst_outputs", {dot_pulse, dash_pulse, done_pulse, space_pulse, overflow}, 0);
    hold(3); reset_n = 1; hold(20);
    chk("rst_held_key_no_press", busy, 0);
    key = 0; hold(8);
    plainDot();

    hold(5);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
